des_frame_ctrl: RTL and testbench

- Frame controller that sequences the serial deserializer (`des`). Detects a start bit on the serial line, enables the deserializer for exactly WIDTH shifts, then checks the stop bit.
- On a good stop bit, latches the deserializer's parallel output into a holding register and presents it downstream on a valid/ready handshake.
- Reports framing errors and overruns, and counts good frames.

---
 rtl/des_frame_ctrl_if.sv | 11 +
 rtl/des_frame_ctrl.sv | 112 +++++++++++
 tb/tb_des_frame_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/des_frame_ctrl_if.sv
// Downstream word handshake between the frame controller and its consumer.
interface des_frame_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready;

    modport master (output word, output word_valid, input word_ready);
    modport slave  (input word, input word_valid, output word_ready);
endinterface

// File: rtl/des_frame_ctrl.sv
// Frame controller for the serial deserializer: start-bit detect, WIDTH-shift
// sequencing, stop-bit check, holding register with valid/ready, error/overrun pulses.
module des_frame_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    output logic             des_en,
    output logic             des_clr,
    input  logic [WIDTH-1:0] des_out,
    des_frame_ctrl_if.master dn,
    output logic             frame_err,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned BCW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [BCW-1:0]   bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] word_q, word_n;
    logic             valid_q, valid_n;
    logic             err_n, ovr_n;
    logic [CNT_W-1:0] cnt_n;
    logic             draining;

    assign dn.word       = word_q;
    assign dn.word_valid = valid_q;
    assign draining      = !valid_q || dn.word_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            word_q    <= word_n;
            valid_q   <= valid_n;
            frame_err <= err_n;
            overrun   <= ovr_n;
            frame_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        word_n    = word_q;
        valid_n   = valid_q;
        err_n     = 1'b0;
        ovr_n     = 1'b0;
        cnt_n     = frame_cnt;
        des_en    = 1'b0;
        des_clr   = 1'b0;

        // Consumption first; a capture at the same edge overrides it below.
        if (valid_q && dn.word_ready) begin
            valid_n = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (in) begin
                    des_clr   = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                des_en    = 1'b1;
                bit_cnt_n = bit_cnt + BCW'(1);
                if (bit_cnt == BCW'(WIDTH - 1)) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                state_n = IDLE;
                if (in) begin
                    err_n = 1'b1;
                end else if (draining) begin
                    word_n  = des_out;
                    valid_n = 1'b1;
                    cnt_n   = frame_cnt + CNT_W'(1);
                end else begin
                    ovr_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Deserializer controls must stay quiet while reset is held.
        if (reset) begin
            des_en  = 1'b0;
            des_clr = 1'b0;
        end
    end

endmodule

// File: tb/tb_des_frame_ctrl.sv
// Bench for des_frame_ctrl: two instances (CNT_W=8 and CNT_W=2) on shared stimulus,
// each with a behavioural deserializer, checked against a frame-level model.
module tb_des_frame_ctrl;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset;
    logic ser;
    logic rdy;

    logic         en_a, clr_a, err_a, ovr_a;
    logic         en_b, clr_b, err_b, ovr_b;
    logic [W-1:0] sr_a, sr_b;
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_b;

    des_frame_ctrl_if #(.WIDTH(W)) if_a ();
    des_frame_ctrl_if #(.WIDTH(W)) if_b ();
    assign if_a.word_ready = rdy;
    assign if_b.word_ready = rdy;

    des_frame_ctrl #(.WIDTH(W), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .in(ser), .des_en(en_a), .des_clr(clr_a),
        .des_out(sr_a), .dn(if_a.master), .frame_err(err_a), .overrun(ovr_a),
        .frame_cnt(cnt_a)
    );

    des_frame_ctrl #(.WIDTH(W), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .in(ser), .des_en(en_b), .des_clr(clr_b),
        .des_out(sr_b), .dn(if_b.master), .frame_err(err_b), .overrun(ovr_b),
        .frame_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    // Behavioural deserializers: left shift of the serial line into the LSB.
    always @(posedge clk) begin
        if (clr_a) sr_a <= '0;
        else if (en_a) sr_a <= {sr_a[W-2:0], ser};
        if (clr_b) sr_b <= '0;
        else if (en_b) sr_b <= {sr_b[W-2:0], ser};
    end

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] exp_word;
    logic         exp_valid;
    logic         exp_err;
    logic         exp_ovr;
    int           exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        chk("word_a",  32'(if_a.word),       32'(exp_word));
        chk("valid_a", 32'(if_a.word_valid), 32'(exp_valid));
        chk("err_a",   32'(err_a),           32'(exp_err));
        chk("ovr_a",   32'(ovr_a),           32'(exp_ovr));
        chk("cnt_a",   32'(cnt_a),           32'(exp_cnt % 256));
        chk("word_b",  32'(if_b.word),       32'(exp_word));
        chk("valid_b", 32'(if_b.word_valid), 32'(exp_valid));
        chk("cnt_b",   32'(cnt_b),           32'(exp_cnt % 4));
    endtask

    task automatic model_reset();
        exp_word  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_ovr   = 1'b0;
        exp_cnt   = 0;
    endtask

    // One clock: phase 0 idle, 1 start bit, 2 data bit, 3 stop bit.
    task automatic cycle(input logic in_v, input logic rdy_v, input int phase,
                         input logic [W-1:0] data);
        logic capture;
        ser = in_v;
        rdy = rdy_v;
        #1;
        chk("des_en_a",  32'(en_a),  32'(phase == 2));
        chk("des_clr_a", 32'(clr_a), 32'(phase == 1));
        chk("des_en_b",  32'(en_b),  32'(phase == 2));
        @(posedge clk);
        capture = (phase == 3) && !in_v;
        exp_err = (phase == 3) && in_v;
        exp_ovr = capture && exp_valid && !rdy_v;
        if (capture && (!exp_valid || rdy_v)) begin
            exp_word  = data;
            exp_valid = 1'b1;
            exp_cnt++;
        end else if (exp_valid && rdy_v) begin
            exp_valid = 1'b0;
        end
        #1;
        check_regs();
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic stop_bit,
                              input logic rdy_body, input logic rdy_stop, input bit rnd);
        cycle(1'b1, rnd ? 1'($urandom) : rdy_body, 1, data);
        for (int i = 0; i < int'(W); i++)
            cycle(data[W-1-i], rnd ? 1'($urandom) : rdy_body, 2, data);
        cycle(stop_bit, rnd ? 1'($urandom) : rdy_stop, 3, data);
    endtask

    task automatic idle(input int n, input logic rdy_v);
        for (int i = 0; i < n; i++) cycle(1'b0, rdy_v, 0, '0);
    endtask

    task automatic apply_reset();
        ser   = 1'b1;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_des_en",  32'(en_a),  32'(0));
        chk("rst_des_clr", 32'(clr_a), 32'(0));
        check_regs();
        @(posedge clk);
        #1;
        check_regs();
        reset = 1'b0;
        ser   = 1'b0;
    endtask

    logic [W-1:0] rd;

    initial begin
        reset = 1'b1;
        ser   = 1'b0;
        rdy   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        reset = 1'b0;
        idle(2, 1'b1);

        // Basic good frame, consumer always ready.
        send_frame(8'hF0, 1'b0, 1'b1, 1'b1, 0);
        chk("f0_word", 32'(if_a.word), 32'h0000_00F0);
        idle(2, 1'b1);

        // Bad stop bit, then line held high is an immediate new start.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0);
        chk("a5_err", 32'(err_a), 32'h1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 0);
        chk("c3_ovr", 32'(ovr_a), 32'h1);
        chk("held_3c", 32'(if_a.word), 32'h0000_003C);
        idle(2, 1'b1);

        // Ready coincides with the stop bit while full: replace, no overrun.
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0);
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 0);
        chk("swap_word", 32'(if_a.word), 32'h0000_0096);
        idle(2, 1'b1);

        // Reset after four data bits aborts the frame.
        cycle(1'b1, 1'b1, 1, 8'h00);
        for (int i = 0; i < 4; i++) cycle(1'(i % 2), 1'b1, 2, 8'h00);
        apply_reset();
        idle(1, 1'b1);
        send_frame(8'h3F, 1'b0, 1'b1, 1'b1, 0);
        chk("3f_cnt", 32'(cnt_a), 32'h1);
        idle(1, 1'b1);

        // Counter wrap on the narrow instance.
        for (int f = 0; f < 5; f++) begin
            send_frame(8'(f * 37 + 1), 1'b0, 1'b1, 1'b1, 0);
            idle(1, 1'b1);
        end

        // Randomised frames, stop bits, gaps and ready.
        for (int f = 0; f < 60; f++) begin
            rd = W'($urandom);
            send_frame(rd, ($urandom_range(0, 4) == 0), 1'b0, 1'b0, 1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 1'($urandom));
        end
        idle(3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
